// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// The immediate-extension mode is selected in alu_instr_decode by the
// ALU_SEQ_IMM_SIGN_EXT_EN macro.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  localparam logic [3:0]  OP_REG    = 4'b0000;
  localparam logic [3:0]  OP_CMP    = 4'b1011;
  localparam logic [15:0] INSTR_NOP = 16'h0000;

  typedef struct packed {
    logic [4:0]  control1;
    logic [4:0]  control2;
    logic [7:0]  opcode;
    logic        imm_control;
    logic [15:0] immediate;
    logic [3:0]  rdest;
    logic        wb_en;
  } dec_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational instruction decode: operand selects, ALU opcode,
// extended immediate and the writeback flag.
// Macro ALU_SEQ_IMM_SIGN_EXT_EN: sign-extend the 8-bit immediate
// (default build zero-extends it).
module alu_instr_decode
  import alu_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [3:0] op;
  assign op = instr[15:12];

  function automatic logic [15:0] ext_imm(input logic [7:0] imm);
`ifdef ALU_SEQ_IMM_SIGN_EXT_EN
    logic signed [7:0] simm;
    simm = imm;
    return {{8{simm[7]}}, simm};
`else
    return {8'h00, imm};
`endif
  endfunction

  // Field extraction; register ops take operand B from rsrc, all others
  // from the immediate, and only immediate ops drive a nonzero immediate.
  always_comb begin
    dec          = '0;
    dec.rdest    = instr[11:8];
    dec.control1 = {1'b0, instr[11:8]};
    if (op == OP_REG) begin
      dec.control2 = {1'b0, instr[3:0]};
      dec.opcode   = {op, instr[7:4]};
    end else begin
      dec.opcode      = {op, 4'b0000};
      dec.imm_control = 1'b1;
      dec.immediate   = ext_imm(instr[7:0]);
    end
    dec.wb_en = !((op == OP_CMP) || (instr == INSTR_NOP));
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer (IDLE -> DECODE -> EXEC -> WB) driving
// ALU operand selects, register-bank write enable and a retired count.
// Every output is registered from the next state, so each output changes
// on the same edge the FSM enters the state it belongs to.
// Macro ALU_SEQ_IMM_SIGN_EXT_EN (see alu_instr_decode) selects sign
// extension of the immediate.
module alu_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] enable,
  output logic [4:0]  control1,
  output logic [4:0]  control2,
  output logic        imm_control,
  output logic [7:0]  opcode,
  output logic [15:0] immediate,
  output logic        buff_en,
  output logic        done,
  output logic [15:0] instr_count
);

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] instr_sel;
  dec_t        dec;

  logic        ready_d;
  logic [15:0] enable_d;
  logic [4:0]  control1_d;
  logic [4:0]  control2_d;
  logic        imm_control_d;
  logic [7:0]  opcode_d;
  logic [15:0] immediate_d;
  logic        buff_en_d;
  logic        done_d;
  logic [15:0] count_d;

  // In IDLE decode the incoming word so DECODE outputs appear on the
  // accept edge; afterwards decode the latched copy.
  assign instr_sel = (state_q == ST_IDLE) ? instr : instr_q;

  alu_instr_decode u_decode (
    .instr (instr_sel),
    .dec   (dec)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Instruction latch, loaded only on accept
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && instr_valid) instr_q <= instr;
  end

  // Next state and next output values
  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b0;
    enable_d      = '0;
    control1_d    = '0;
    control2_d    = '0;
    imm_control_d = 1'b0;
    opcode_d      = '0;
    immediate_d   = '0;
    buff_en_d     = 1'b0;
    done_d        = 1'b0;
    count_d       = instr_count;

    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      ready_d = 1'b1;
    end else begin
      control1_d    = dec.control1;
      control2_d    = dec.control2;
      imm_control_d = dec.imm_control;
      opcode_d      = dec.opcode;
      immediate_d   = dec.immediate;
    end

    if (state_d == ST_EXEC || state_d == ST_WB) buff_en_d = 1'b1;

    if (state_d == ST_WB) begin
      done_d  = 1'b1;
      count_d = instr_count + 16'd1;
      if (dec.wb_en) enable_d = 16'h0001 << dec.rdest;
    end
  end

  // Output registers; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_ready <= 1'b1;
      enable      <= '0;
      control1    <= '0;
      control2    <= '0;
      imm_control <= 1'b0;
      opcode      <= '0;
      immediate   <= '0;
      buff_en     <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
    end else begin
      instr_ready <= ready_d;
      enable      <= enable_d;
      control1    <= control1_d;
      control2    <= control2_d;
      imm_control <= imm_control_d;
      opcode      <= opcode_d;
      immediate   <= immediate_d;
      buff_en     <= buff_en_d;
      done        <= done_d;
      instr_count <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomized bench for alu_sequencer against a field-level
// reference model of the instruction set.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] enable;
  logic [4:0]  control1, control2;
  logic        imm_control;
  logic [7:0]  opcode;
  logic [15:0] immediate;
  logic        buff_en;
  logic        done;
  logic [15:0] instr_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_count = 16'h0000;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .enable      (enable),
    .control1    (control1),
    .control2    (control2),
    .imm_control (imm_control),
    .opcode      (opcode),
    .immediate   (immediate),
    .buff_en     (buff_en),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---- reference model ----
  function automatic int f_op(input logic [15:0] i);
    return int'(i) / 4096;
  endfunction

  function automatic logic [4:0] m_c1(input logic [15:0] i);
    return 5'((int'(i) / 256) % 16);
  endfunction

  function automatic logic [4:0] m_c2(input logic [15:0] i);
    return (f_op(i) == 0) ? 5'(int'(i) % 16) : 5'd0;
  endfunction

  function automatic logic [7:0] m_opcode(input logic [15:0] i);
    if (f_op(i) == 0) return 8'((int'(i) / 16) % 16);
    return 8'(f_op(i) * 16);
  endfunction

  function automatic logic m_immctl(input logic [15:0] i);
    return f_op(i) != 0;
  endfunction

  function automatic logic [15:0] m_imm(input logic [15:0] i);
    int b;
    if (f_op(i) == 0) return 16'h0000;
    b = int'(i) % 256;
`ifdef ALU_SEQ_IMM_SIGN_EXT_EN
    if (b >= 128) b = b - 256;
`endif
    return 16'(b);
  endfunction

  function automatic logic [15:0] m_enable(input logic [15:0] i);
    if (f_op(i) == 11 || i == 16'h0000) return 16'h0000;
    return 16'(1 << ((int'(i) / 256) % 16));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and check every cycle until it has retired.
  task automatic run_instr(input logic [15:0] i);
    int w;
    w = 0;
    while (instr_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    instr = i;
    instr_valid = 1'b1;
    @(negedge clk);
    // DECODE; scramble inputs to show the word was latched and valid ignored
    instr = 16'($urandom);
    instr_valid = 1'($urandom);
    chk("dec_ready",   {31'd0, instr_ready}, 32'd0);
    chk("dec_buff",    {31'd0, buff_en},     32'd0);
    chk("dec_enable",  {16'd0, enable},      32'd0);
    chk("dec_done",    {31'd0, done},        32'd0);
    chk("dec_c1",      {27'd0, control1},    {27'd0, m_c1(i)});
    chk("dec_c2",      {27'd0, control2},    {27'd0, m_c2(i)});
    chk("dec_opcode",  {24'd0, opcode},      {24'd0, m_opcode(i)});
    chk("dec_immctl",  {31'd0, imm_control}, {31'd0, m_immctl(i)});
    chk("dec_imm",     {16'd0, immediate},   {16'd0, m_imm(i)});
    @(negedge clk);
    // EXEC
    instr_valid = 1'($urandom);
    chk("exec_buff",   {31'd0, buff_en},     32'd1);
    chk("exec_enable", {16'd0, enable},      32'd0);
    chk("exec_done",   {31'd0, done},        32'd0);
    chk("exec_opcode", {24'd0, opcode},      {24'd0, m_opcode(i)});
    chk("exec_c2",     {27'd0, control2},    {27'd0, m_c2(i)});
    @(negedge clk);
    // WB
    instr_valid = 1'b0;
    model_count = model_count + 16'd1;
    chk("wb_enable",   {16'd0, enable},      {16'd0, m_enable(i)});
    chk("wb_done",     {31'd0, done},        32'd1);
    chk("wb_buff",     {31'd0, buff_en},     32'd1);
    chk("wb_count",    {16'd0, instr_count}, {16'd0, model_count});
    chk("wb_c1",       {27'd0, control1},    {27'd0, m_c1(i)});
    chk("wb_imm",      {16'd0, immediate},   {16'd0, m_imm(i)});
    chk("wb_ready",    {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    // back in IDLE
    chk("idle_ready",  {31'd0, instr_ready}, 32'd1);
    chk("idle_done",   {31'd0, done},        32'd0);
    chk("idle_enable", {16'd0, enable},      32'd0);
    chk("idle_buff",   {31'd0, buff_en},     32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = 16'h0312;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    model_count = 16'h0000;
  endtask

  logic [15:0] hold_list [3];
  logic [15:0] r;

  initial begin
    reset = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    @(negedge clk);

    // reset state, with instr_valid asserted alongside reset
    do_reset();
    chk("rst_ready",  {31'd0, instr_ready}, 32'd1);
    chk("rst_enable", {16'd0, enable},      32'd0);
    chk("rst_done",   {31'd0, done},        32'd0);
    chk("rst_buff",   {31'd0, buff_en},     32'd0);
    chk("rst_count",  {16'd0, instr_count}, 32'd0);
    chk("rst_c1",     {27'd0, control1},    32'd0);
    chk("rst_imm",    {16'd0, immediate},   32'd0);

    // directed instructions
    run_instr(16'h0312);
    run_instr(16'h52F0);
    run_instr(16'hB123);
    run_instr(16'h0000);
    run_instr(16'h6F7F);

    // randomized instructions, biased towards compare / NOP corners
    for (int n = 0; n < 24; n++) begin
      r = 16'($urandom);
      if (n % 6 == 1) r = {4'hB, r[11:0]};
      if (n % 6 == 3) r = {4'h0, r[11:0]};
      if (n == 10) r = 16'h0000;
      run_instr(r);
    end

    // instr_valid held high across three back-to-back instructions
    hold_list[0] = 16'h0312;
    hold_list[1] = 16'h52F0;
    hold_list[2] = 16'h7A05;
    chk("hold_start_ready", {31'd0, instr_ready}, 32'd1);
    instr = hold_list[0];
    instr_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("hold_ready", {31'd0, instr_ready}, {31'd0, (k % 4 == 0)});
      chk("hold_done",  {31'd0, done},        {31'd0, (k % 4 == 3)});
      if (k % 4 == 3) begin
        model_count = model_count + 16'd1;
        chk("hold_count",  {16'd0, instr_count}, {16'd0, model_count});
        chk("hold_enable", {16'd0, enable},      {16'd0, m_enable(hold_list[k / 4])});
      end
      if (k % 4 == 0 && k < 12) instr = hold_list[k / 4];
      if (k == 12) instr_valid = 1'b0;
    end

    // reset in the EXEC cycle aborts the instruction
    do_reset();
    instr = 16'h0312;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_exec", {31'd0, buff_en}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready",  {31'd0, instr_ready}, 32'd1);
    chk("abort_enable", {16'd0, enable},      32'd0);
    chk("abort_done",   {31'd0, done},        32'd0);
    chk("abort_buff",   {31'd0, buff_en},     32'd0);
    chk("abort_count",  {16'd0, instr_count}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet_done",   {31'd0, done},   32'd0);
      chk("abort_quiet_enable", {16'd0, enable}, 32'd0);
    end

    // counter wrap: 65535 NOPs back to back, then one more instruction
    instr = 16'h0000;
    instr_valid = 1'b1;
    repeat (4 * 65535) @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    model_count = 16'hFFFF;
    chk("preload_count", {16'd0, instr_count}, 32'h0000FFFF);
    chk("preload_ready", {31'd0, instr_ready}, 32'd1);
    run_instr(16'h2A11);
    chk("wrap_count", {16'd0, instr_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
